alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
Command buffer and issue stage directly upstream of the 4-bit registered ALU. Accepts ALU commands (a, b, ctl) over a valid/ready handshake and holds them in a small FIFO. Issues at most one command per cycle onto the ALU input bus (valid_in, a, b, ctl). Owns the carry flag register that drives the ALU cin, with same-cycle forwarding so back-to-back ADD_c/SUB_b chains see the previous op's carry.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
W, 4, operand width (must match ALU)
ERRW, 8, width of illegal-opcode counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  queue can accept (= !full)
cmd_a  in  W  operand A
cmd_b  in  W  operand B
cmd_ctl  in  4  opcode (opcode_e encoding)
issue_en  in  1  1 = issue permitted this cycle; 0 = hold queue
flag_clr  in  1  synchronous clear of carry flag
alu_valid_out  in  1  ALU output valid
alu_carry  in  1  ALU carry output
valid_in  out  1  to ALU: command valid
a  out  W  to ALU port A
b  out  W  to ALU port B
ctl  out  4  to ALU opcode
cin  out  1  to ALU carry in
level  out  $clog2(DEPTH+1)  current FIFO occupancy
err_cnt  out  ERRW  count of dropped illegal opcodes

Behaviour:
- Reset (async, reset=0): FIFO empty, pointers 0, level=0, valid_in=0, a=b=ctl=0, carry_flag=0, err_cnt=0. Reset mid-stream flushes all queued commands; nothing is reissued after release.
- Handshake: transfer when cmd_valid && cmd_ready. cmd_ready = (level != DEPTH), registered-state derived, no combinational path from cmd_valid.
- Legality: ctl 0..13 are legal (SEL..ROTATE_R). A transfer with ctl 14/15 completes the handshake but is not written. err_cnt increments by 1, saturates at 2^ERRW-1.
- FIFO: circular buffer, read/write pointers wrap at DEPTH. Push on legal transfer, pop when issue fires. When full, push is blocked even if a pop occurs that cycle. Simultaneous push+pop when 0<level<DEPTH: level unchanged.
- Issue: fires on a clock edge when level != 0 && issue_en. At that edge: valid_in<=1, {a,b,ctl}<=head entry. Otherwise valid_in<=0, and a/b/ctl hold their last values.
- Rate: one command per cycle max.
- Latency: command accepted in cycle N appears on valid_in in cycle N+2 minimum (no empty-queue bypass).
- issue_en=0 with a non-empty queue: valid_in drops to 0 the next cycle. Queue contents are preserved.
- Carry flag:
  - carry_flag <= alu_carry whenever alu_valid_out=1.
  - flag_clr=1 forces carry_flag<=0 and has priority over the update in the same cycle.
- cin (combinational): alu_valid_out ? alu_carry : carry_flag. This forwards the result of the op issued in cycle N-1 to the op presented in cycle N.
- Every ALU op, including logic/shift ops, overwrites carry_flag with the ALU's carry output.
- level: registered and exact. err_cnt: registered.

Decomposition:
- Shared package (macro_pkg): opcode_e with encodings SEL=0, INC=1, DEC=2, ADD=3, ADD_c=4, SUB=5, SUB_b=6, AND=7, OR=8, XOR=9, SHIFT_L=10, SHIFT_R=11, ROTATE_L=12, ROTATE_R=13; constant OPCODE_MAX=13.
- One sub-module, alu_cmd_fifo: generic sync FIFO with push, pop, full, empty, level, parameterised on width and DEPTH.
- Issue register, legality check and carry flag logic live in the top.

Test Plan:
- Reset then idle -> all outputs 0, cmd_ready=1, level=0; assert reset mid-stream with level=3 -> level=0, valid_in=0 immediately, and nothing issues after release.
- issue_en=0, push 5 commands back-to-back -> first 4 accepted, cmd_ready=0 at level=4, 5th held. Raise issue_en -> 4 consecutive valid_in cycles in FIFO order, then 5th accepted and issued.
- Push ADD a=F b=1, then ADD_c a=0 b=0, with issue_en=1 and a model ALU -> ADD_c cycle sees cin=1 (forwarded), ALU result 1. carry_flag=0 after the ADD_c result.
- Push ctl=14, then ctl=15, then SEL b=7 -> err_cnt=2, only SEL issued (ctl=0, b=7). Force err_cnt to max with ERRW=2 -> stays 3.
- carry_flag=1, pulse flag_clr in the same cycle as alu_valid_out=1, alu_carry=1 -> carry_flag=0 next cycle.
- level=2, push and pop in the same cycle -> level stays 2, correct order preserved across pointer wrap (issue 10 commands total).

Source files
------------

// File: rtl/macro_pkg.sv
// Shared ALU opcode encoding and legality helper for the issue queue and ALU.
package macro_pkg;

  typedef enum logic [3:0] {
    SEL      = 4'd0,
    INC      = 4'd1,
    DEC      = 4'd2,
    ADD      = 4'd3,
    ADD_c    = 4'd4,
    SUB      = 4'd5,
    SUB_b    = 4'd6,
    AND      = 4'd7,
    OR       = 4'd8,
    XOR      = 4'd9,
    SHIFT_L  = 4'd10,
    SHIFT_R  = 4'd11,
    ROTATE_L = 4'd12,
    ROTATE_R = 4'd13
  } opcode_e;

  localparam logic [3:0] OPCODE_MAX = 4'd13;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OPCODE_MAX;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous circular FIFO; head entry is presented combinationally on dout.
module alu_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read when level says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Command buffer and issue register feeding the 4-bit ALU; owns the carry flag and cin forwarding.
module alu_issue_queue
  import macro_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int ERRW  = 8,
  localparam int LW   = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  input  logic [3:0]      cmd_ctl,
  input  logic            issue_en,
  input  logic            flag_clr,
  input  logic            alu_valid_out,
  input  logic            alu_carry,
  output logic            valid_in,
  output logic [W-1:0]    a,
  output logic [W-1:0]    b,
  output logic [3:0]      ctl,
  output logic            cin,
  output logic [LW-1:0]   level,
  output logic [ERRW-1:0] err_cnt
);

  localparam int CW = 2*W + 4;

  logic [CW-1:0]   head;
  logic            full, empty, xfer, push, issue;
  logic            valid_in_q, valid_in_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [3:0]      ctl_q, ctl_d;
  logic            carry_flag_q, carry_flag_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;

  assign cmd_ready = !full;
  assign xfer      = cmd_valid && cmd_ready;
  // Illegal opcodes complete the handshake but never enter the queue.
  assign push      = xfer && is_legal(cmd_ctl);
  assign issue     = !empty && issue_en;

  alu_cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (issue),
    .din   ({cmd_a, cmd_b, cmd_ctl}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    valid_in_d   = issue;
    a_d          = a_q;
    b_d          = b_q;
    ctl_d        = ctl_q;
    carry_flag_d = carry_flag_q;
    err_cnt_d    = err_cnt_q;
    if (issue) {a_d, b_d, ctl_d} = head;
    if (flag_clr)           carry_flag_d = 1'b0;
    else if (alu_valid_out) carry_flag_d = alu_carry;
    if (xfer && !is_legal(cmd_ctl) && (err_cnt_q != {ERRW{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_in_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctl_q        <= '0;
      carry_flag_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      valid_in_q   <= valid_in_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctl_q        <= ctl_d;
      carry_flag_q <= carry_flag_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign valid_in = valid_in_q;
  assign a        = a_q;
  assign b        = b_q;
  assign ctl      = ctl_q;
  assign err_cnt  = err_cnt_q;
  // Forward the in-flight carry so chained ADD_c/SUB_b see the previous op's result.
  assign cin      = alu_valid_out ? alu_carry : carry_flag_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, backpressure, legality, carry forwarding, wrap.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, issue_en, flag_clr, alu_valid_out, alu_carry;
  logic [3:0] cmd_a, cmd_b, cmd_ctl;
  logic       cmd_ready, valid_in, cin;
  logic [3:0] a, b, ctl;
  logic [2:0] level;
  logic [7:0] err_cnt;

  logic       cmd_ready2, valid_in2, cin2;
  logic [3:0] a2, b2, ctl2;
  logic [2:0] level2;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4), .W(4), .ERRW(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctl(cmd_ctl), .issue_en(issue_en),
    .flag_clr(flag_clr), .alu_valid_out(alu_valid_out), .alu_carry(alu_carry),
    .valid_in(valid_in), .a(a), .b(b), .ctl(ctl), .cin(cin),
    .level(level), .err_cnt(err_cnt)
  );

  // Narrow error counter copy, used only to observe saturation.
  alu_issue_queue #(.DEPTH(4), .W(4), .ERRW(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctl(cmd_ctl), .issue_en(issue_en),
    .flag_clr(flag_clr), .alu_valid_out(alu_valid_out), .alu_carry(alu_carry),
    .valid_in(valid_in2), .a(a2), .b(b2), .ctl(ctl2), .cin(cin2),
    .level(level2), .err_cnt(err_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                           input logic [3:0] ic);
    cmd_valid = v; cmd_a = ia; cmd_b = ib; cmd_ctl = ic;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_ctl = 0;
    issue_en = 0; flag_clr = 0; alu_valid_out = 0; alu_carry = 0;
    step(); step();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({valid_in, a, b, ctl, cin} !== 14'h0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", {valid_in, a, b, ctl, cin});
    end
    checks++;
    if (cmd_ready !== 1'b1 || level !== 3'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_status: got rdy=%b lvl=%0d err=%0d exp rdy=1 lvl=0 err=0",
                          cmd_ready, level, err_cnt);
    end
    // Fill three entries, then reset asynchronously in mid-cycle.
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1, 4'(i + 1), 4'(i + 5), 4'd3);
      step();
    end
    drive_cmd(0, 0, 0, 0);
    checks++;
    if (level !== 3'd3) begin
      errors++; $display("FAIL pre_reset_level: got %0d exp 3", level);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (level !== 3'd0 || valid_in !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL async_flush: got lvl=%0d vin=%b rdy=%b exp 0 0 1",
                          level, valid_in, cmd_ready);
    end
    step();
    reset = 1'b1;
    issue_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid_in !== 1'b0 || level !== 3'd0) begin
        errors++; $display("FAIL no_reissue: cyc %0d got vin=%b lvl=%0d exp 0 0", i, valid_in, level);
      end
    end
    issue_en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_a, exp_b, exp_c;
    issue_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1, 4'(i + 1), 4'(i + 8), 4'(i));
      checks++;
      if (cmd_ready !== (i < 4)) begin
        errors++; $display("FAIL bp_ready: push %0d got %b exp %b", i, cmd_ready, (i < 4));
      end
      step();
    end
    checks++;
    if (level !== 3'd4 || cmd_ready !== 1'b0 || valid_in !== 1'b0) begin
      errors++; $display("FAIL bp_full: got lvl=%0d rdy=%b vin=%b exp 4 0 0", level, cmd_ready, valid_in);
    end
    issue_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) cmd_valid = 1'b0;
      exp_a = 4'(i + 1); exp_b = 4'(i + 8); exp_c = 4'(i);
      checks++;
      if (valid_in !== 1'b1 || a !== exp_a || b !== exp_b || ctl !== exp_c) begin
        errors++; $display("FAIL bp_drain: issue %0d got v=%b a=%h b=%h c=%h exp 1 %h %h %h",
                            i, valid_in, a, b, ctl, exp_a, exp_b, exp_c);
      end
    end
    step();
    checks++;
    if (valid_in !== 1'b0 || level !== 3'd0 || a !== 4'd5 || ctl !== 4'd4) begin
      errors++; $display("FAIL bp_idle_hold: got v=%b lvl=%0d a=%h c=%h exp 0 0 5 4",
                          valid_in, level, a, ctl);
    end
  endtask

  task automatic test_illegal();
    int nissue = 0;
    issue_en = 1'b1;
    drive_cmd(1, 4'd1, 4'd1, 4'd14); step();
    drive_cmd(1, 4'd1, 4'd1, 4'd15); step();
    drive_cmd(1, 4'd2, 4'd7, 4'd0);  step();
    drive_cmd(0, 0, 0, 0);
    checks++;
    if (err_cnt !== 8'd2 || err_cnt2 !== 2'd2 || level !== 3'd1) begin
      errors++; $display("FAIL illegal_count: got err=%0d err2=%0d lvl=%0d exp 2 2 1",
                          err_cnt, err_cnt2, level);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (valid_in === 1'b1) begin
        nissue++;
        checks++;
        if (ctl !== 4'd0 || b !== 4'd7 || a !== 4'd2) begin
          errors++; $display("FAIL illegal_issue_data: got a=%h b=%h c=%h exp 2 7 0", a, b, ctl);
        end
      end
    end
    checks++;
    if (nissue != 1) begin
      errors++; $display("FAIL illegal_issue_count: got %0d exp 1", nissue);
    end
    drive_cmd(1, 0, 0, 4'd15); step(); step();
    checks++;
    if (err_cnt2 !== 2'd3 || err_cnt !== 8'd4) begin
      errors++; $display("FAIL err_reach_max: got err2=%0d err=%0d exp 3 4", err_cnt2, err_cnt);
    end
    step();
    drive_cmd(0, 0, 0, 0);
    checks++;
    if (err_cnt2 !== 2'd3 || err_cnt !== 8'd5) begin
      errors++; $display("FAIL err_saturate: got err2=%0d err=%0d exp 3 5", err_cnt2, err_cnt);
    end
  endtask

  task automatic test_carry_chain();
    logic [4:0] alu_sum;
    issue_en = 1'b1;
    drive_cmd(1, 4'hF, 4'h1, 4'd3); step();
    drive_cmd(1, 4'h0, 4'h0, 4'd4); step();
    drive_cmd(0, 0, 0, 0);
    checks++;
    if (valid_in !== 1'b1 || ctl !== 4'd3 || cin !== 1'b0) begin
      errors++; $display("FAIL carry_add_issue: got v=%b c=%h cin=%b exp 1 3 0", valid_in, ctl, cin);
    end
    step();
    // ALU returns ADD F+1: result 0, carry 1, while ADD_c is on the bus.
    alu_valid_out = 1'b1; alu_carry = 1'b1;
    #1;
    alu_sum = 5'(a) + 5'(b) + 5'(cin);
    checks++;
    if (valid_in !== 1'b1 || ctl !== 4'd4 || cin !== 1'b1) begin
      errors++; $display("FAIL carry_forward: got v=%b c=%h cin=%b exp 1 4 1", valid_in, ctl, cin);
    end
    checks++;
    if (alu_sum !== 5'h01) begin
      errors++; $display("FAIL carry_addc_result: got %h exp 01", alu_sum);
    end
    step();
    alu_valid_out = 1'b1; alu_carry = 1'b0;
    step();
    alu_valid_out = 1'b0; alu_carry = 1'b0;
    #1;
    checks++;
    if (cin !== 1'b0) begin
      errors++; $display("FAIL carry_after_addc: got %b exp 0", cin);
    end
  endtask

  task automatic test_flag_clr();
    alu_valid_out = 1'b1; alu_carry = 1'b1;
    step();
    alu_valid_out = 1'b0; alu_carry = 1'b0;
    #1;
    checks++;
    if (cin !== 1'b1) begin
      errors++; $display("FAIL flag_set: got %b exp 1", cin);
    end
    flag_clr = 1'b1; alu_valid_out = 1'b1; alu_carry = 1'b1;
    step();
    flag_clr = 1'b0; alu_valid_out = 1'b0; alu_carry = 1'b0;
    #1;
    checks++;
    if (cin !== 1'b0) begin
      errors++; $display("FAIL flag_clr_priority: got %b exp 0", cin);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ea, eb, ec;
    issue_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_cmd(1, 4'(k), 4'(15 - k), 4'(k + 3));
      step();
    end
    checks++;
    if (level !== 3'd2) begin
      errors++; $display("FAIL wrap_prefill: got %0d exp 2", level);
    end
    issue_en = 1'b1;
    for (int k = 2; k < 12; k++) begin
      if (k < 10) drive_cmd(1, 4'(k), 4'(15 - k), 4'(k + 3));
      else        drive_cmd(0, 0, 0, 0);
      step();
      ea = 4'(k - 2); eb = 4'(17 - k); ec = 4'(k + 1);
      checks++;
      if (valid_in !== 1'b1 || a !== ea || b !== eb || ctl !== ec) begin
        errors++; $display("FAIL wrap_order: issue %0d got v=%b a=%h b=%h c=%h exp 1 %h %h %h",
                            k - 2, valid_in, a, b, ctl, ea, eb, ec);
      end
      checks++;
      if (level !== ((k < 10) ? 3'd2 : 3'(11 - k))) begin
        errors++; $display("FAIL wrap_level: step %0d got %0d exp %0d",
                            k, level, (k < 10) ? 2 : 11 - k);
      end
    end
    step();
    checks++;
    if (valid_in !== 1'b0) begin
      errors++; $display("FAIL wrap_done: got %b exp 0", valid_in);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_illegal();
    test_carry_chain();
    test_flag_clr();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
